// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle for the run-controlled clock divider.
// The master drives run control and ratio writes; the slave returns the divided outputs.
interface clk_div_ctrl_if #(
  parameter int W = 8
);
  logic         start;
  logic         stop;
  logic         cfg_we;
  logic [W-1:0] cfg_div;
  logic         f_out;
  logic         tick;
  logic         busy;
  logic         cfg_err;
  logic [W-1:0] cur_div;

  modport master (
    output start, stop, cfg_we, cfg_div,
    input  f_out, tick, busy, cfg_err, cur_div
  );

  modport slave (
    input  start, stop, cfg_we, cfg_div,
    output f_out, tick, busy, cfg_err, cur_div
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-controlled divide-by-N clock generator with period-end strobe.
// Ratio changes are deferred to period boundaries so no period is ever truncated.
module clk_div_ctrl #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 4
) (
  input logic          clk,
  input logic          nrst,
  clk_div_ctrl_if.slave bus
);

  if (DEFAULT_DIV < 2 ||
      longint'(DEFAULT_DIV) > ((64'd1 << W) - 64'd1))
  begin : g_bad_div
    $error("clk_div_ctrl: DEFAULT_DIV out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  state_t       state;
  logic [W-1:0] cnt;
  logic [W-1:0] cur_div;
  logic [W-1:0] pend_div;
  logic         pend_valid;
  logic         cfg_err;

  logic         busy;
  logic         wrap;
  logic         wr_ok;
  logic         go;
  logic [W-1:0] half;
  logic [W-1:0] last;

  assign busy  = (state != IDLE);
  assign half  = cur_div - (cur_div >> 1);
  assign last  = cur_div - ONE;
  assign wrap  = busy && (cnt == last);
  assign wr_ok = bus.cfg_we && (bus.cfg_div >= TWO);
  assign go    = bus.start && !bus.stop;

  assign bus.f_out   = busy && (cnt < half);
  assign bus.tick    = wrap;
  assign bus.busy    = busy;
  assign bus.cfg_err = cfg_err;
  assign bus.cur_div = cur_div;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_div    <= W'(DEFAULT_DIV);
      pend_div   <= '0;
      pend_valid <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= bus.cfg_we && !wr_ok;

      unique case (state)
        IDLE: begin
          if (go) state <= RUN;
        end
        RUN: begin
          if (bus.stop) state <= STOPPING;
        end
        STOPPING: begin
          if (go)        state <= RUN;
          else if (wrap) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      cnt <= (!busy || wrap) ? '0 : cnt + ONE;

      // A write landing on the wrap edge takes effect at that wrap.
      if (wrap) begin
        if (wr_ok)           cur_div <= bus.cfg_div;
        else if (pend_valid) cur_div <= pend_div;
        pend_valid <= 1'b0;
      end else begin
        if (!busy && pend_valid) begin
          cur_div    <= pend_div;
          pend_valid <= 1'b0;
        end
        if (wr_ok) begin
          pend_div   <= bus.cfg_div;
          pend_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl.
// Linear stimulus; outputs sampled 1 time unit after each rising edge.
module tb_clk_div_ctrl;
  localparam int W = 8;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int checks   = 0;
  int failures = 0;

  clk_div_ctrl_if #(.W(W)) bus ();

  clk_div_ctrl #(
    .W(W),
    .DEFAULT_DIV(4)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic p4f [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
  logic p4t [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  logic p3f [6] = '{1, 1, 0, 1, 1, 0};
  logic p3t [6] = '{0, 0, 1, 0, 0, 1};
  logic psf [4] = '{1, 0, 0, 0};
  logic pst [4] = '{0, 0, 0, 1};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag,
                      input logic f, input logic t, input logic b);
    chk({tag, "_f"}, 32'(bus.f_out), 32'(f));
    chk({tag, "_t"}, 32'(bus.tick),  32'(t));
    chk({tag, "_b"}, 32'(bus.busy),  32'(b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.cfg_we  = 1'b0;
    bus.cfg_div = '0;

    #12;
    outs("rst", 0, 0, 0);
    chk("rst_div", 32'(bus.cur_div), 4);
    chk("rst_err", 32'(bus.cfg_err), 0);
    nrst = 1'b1;

    // start pulse, default N=4
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      outs($sformatf("n4_%0d", i), p4f[i], p4t[i], 1);
      chk("n4_div", 32'(bus.cur_div), 4);
      step();
    end

    // cnt=0 now; write N=3 at cnt=1
    step();
    bus.cfg_we  = 1'b1;
    bus.cfg_div = 8'd3;
    step();
    bus.cfg_we = 1'b0;
    chk("defer_div2", 32'(bus.cur_div), 4);
    outs("defer_c2", 0, 0, 1);
    step();
    chk("defer_div3", 32'(bus.cur_div), 4);
    outs("defer_c3", 0, 1, 1);
    step();
    chk("apply_div", 32'(bus.cur_div), 3);
    for (int i = 0; i < 6; i++) begin
      outs($sformatf("n3_%0d", i), p3f[i], p3t[i], 1);
      step();
    end

    // rejected writes at cnt=0 and cnt=2
    bus.cfg_we  = 1'b1;
    bus.cfg_div = 8'd0;
    step();
    bus.cfg_we = 1'b0;
    chk("err0_hi", 32'(bus.cfg_err), 1);
    chk("err0_div", 32'(bus.cur_div), 3);
    outs("err0_c1", 1, 0, 1);
    step();
    chk("err0_lo", 32'(bus.cfg_err), 0);
    outs("err0_c2", 0, 1, 1);
    bus.cfg_we  = 1'b1;
    bus.cfg_div = 8'd1;
    step();
    bus.cfg_we = 1'b0;
    chk("err1_hi", 32'(bus.cfg_err), 1);
    chk("err1_div", 32'(bus.cur_div), 3);
    outs("err1_c0", 1, 0, 1);
    step();
    chk("err1_lo", 32'(bus.cfg_err), 0);
    chk("err1_div2", 32'(bus.cur_div), 3);

    // cnt=1; switch to N=6
    bus.cfg_we  = 1'b1;
    bus.cfg_div = 8'd6;
    step();
    bus.cfg_we = 1'b0;
    chk("n6_pre", 32'(bus.cur_div), 3);
    step();
    chk("n6_div", 32'(bus.cur_div), 6);
    outs("n6_c0", 1, 0, 1);
    step();
    outs("n6_c1", 1, 0, 1);

    // stop at cnt=1
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      outs($sformatf("stp_%0d", i), psf[i], pst[i], 1);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      outs($sformatf("idle_%0d", i), 0, 0, 0);
      step();
    end

    // stop then start at cnt=4 resumes
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    outs("rs_c0", 1, 0, 1);
    step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    outs("rs_c2", 1, 0, 1);
    step();
    step();
    outs("rs_c4", 0, 0, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    outs("rs_c5", 0, 1, 1);
    step();
    outs("rs_wrap", 1, 0, 1);
    step();

    // start+stop in RUN -> STOPPING
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    outs("ss_c2", 1, 0, 1);
    step();
    step();
    step();
    outs("ss_c5", 0, 1, 1);
    step();
    outs("ss_idle", 0, 0, 0);

    // start+stop in IDLE stays IDLE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    outs("si_0", 0, 0, 0);
    step();
    outs("si_1", 0, 0, 0);
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    // ratio write in IDLE applies one edge after capture
    bus.cfg_we  = 1'b1;
    bus.cfg_div = 8'd5;
    step();
    bus.cfg_we = 1'b0;
    chk("idle_wr0", 32'(bus.cur_div), 6);
    step();
    chk("idle_wr1", 32'(bus.cur_div), 5);

    // async reset during high phase
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    outs("ar_pre", 1, 0, 1);
    #2 nrst = 1'b0;
    #1;
    outs("ar_mid", 0, 0, 0);
    chk("ar_div", 32'(bus.cur_div), 4);
    #2 nrst = 1'b1;
    step();
    outs("ar_post", 0, 0, 0);
    chk("ar_div2", 32'(bus.cur_div), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-controlled programmable clock divider that sequences a divide-by-N flip-flop chain, generalising the fixed divide-by-4 stage. It starts and stops the divided output cleanly at period boundaries and accepts a new ratio at runtime without glitches. It produces a square wave plus a one-cycle period-end strobe for downstream counters and lab blocks.

Parameters:
W, 8, width of the division ratio and of the period counter.
DEFAULT_DIV, 4, ratio loaded at reset. Must satisfy 2 <= DEFAULT_DIV <= 2^W-1; elaboration error otherwise.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
nrst  input  1  asynchronous active-low reset.
start  input  1  request to start dividing; level sampled each edge.
stop  input  1  request to stop at the end of the current period; sampled each edge.
cfg_we  input  1  ratio write strobe.
cfg_div  input  W  new ratio N; valid with cfg_we.
f_out  output  1  divided clock, period cur_div cycles.
tick  output  1  high during the last clk cycle of each output period.
busy  output  1  high when state is not IDLE.
cfg_err  output  1  one-cycle pulse after a rejected write.
cur_div  output  W  ratio currently in effect.

Behaviour:
- Reset (nrst=0, asynchronous): state=IDLE, cnt=0, cur_div=DEFAULT_DIV, pend_valid=0, cfg_err=0. This forces f_out=0, tick=0, busy=0 immediately, including mid-period.
- States: IDLE, RUN, STOPPING. stop has priority over start in every state.
- IDLE:
  - start=1 and stop=0 -> RUN, cnt=0.
  - Otherwise stay in IDLE.
- RUN:
  - stop=1 -> STOPPING.
  - start is ignored.
- STOPPING:
  - start=1 and stop=0 -> RUN. cnt is undisturbed.
  - At wrap -> IDLE.
- Counter: in RUN or STOPPING, cnt increments each edge. When cnt == cur_div-1 (wrap), cnt returns to 0. cnt is held at 0 in IDLE.
- Outputs (decode of registered state only):
  - H = cur_div - (cur_div>>1), i.e. ceil(N/2).
  - f_out = busy & (cnt < H). Example: N=4 gives 2 cycles high, 2 low. N=3 gives 2 high, 1 low.
  - tick = busy & (cnt == cur_div-1).
- Latency: start sampled at edge k -> f_out=1 in the cycle after edge k. The first period is full length.
- Config writes (cfg_we=1):
  - cfg_div < 2: write ignored, cfg_err=1 for exactly the next cycle, pending state unchanged.
  - Otherwise: pend_div=cfg_div, pend_valid=1. Multiple writes before apply: last wins.
- Apply timing:
  - In IDLE, a pending value loads into cur_div at the next edge.
  - In RUN/STOPPING, it loads only at a wrap edge, so the new period starts with cnt=0 and new H. pend_valid clears on apply.
  - A write in the same cycle as a wrap applies at that wrap.
- STOPPING wrap: enters IDLE and applies any pending ratio. f_out is already 0 at the end of the period (cnt=N-1 >= H), so no runt pulse is possible.
- Reducing N below the current cnt never truncates a period, because the change is deferred to wrap.

Test Plan:
- Reset default, start pulse held 1 cycle: f_out pattern 1,1,0,0 repeating; tick high on every 4th cycle; cur_div=4; busy=1.
- cfg_div=3 written mid-period while running N=4: current period completes with 4 cycles; next periods are 1,1,0; tick every 3 cycles; cur_div changes exactly at the wrap edge.
- cfg_div=0 and then cfg_div=1: each gives a cfg_err pulse of exactly 1 cycle; cur_div and waveform unchanged.
- stop asserted at cnt=1 with N=6: f_out finishes 1,1,1,0,0,0 pattern; busy drops after wrap; no further highs. start at cnt=4 while STOPPING instead resumes without a gap.
- start and stop together in IDLE: stays IDLE, f_out=0. stop and start together in RUN: enters STOPPING.
- nrst pulled low asynchronously mid-high-phase: f_out, tick, busy drop before the next clk edge. After release, cur_div=DEFAULT_DIV and state is IDLE.
